// File: rtl/hazard_unit.sv
// hazard_unit: data/control hazard detection for a 5-stage MIPS-style pipeline.
// Keeps shadow copies of the E, M and W stages and derives ALU operand forwarding,
// load-use and branch stalls, decode flush and a saturating stall-cycle counter.
// Optional feature macro: BRANCH_FWD_EN enables decode-stage branch comparator
// forwarding (forward_ad/forward_bd) and the matching branch stall. Without it,
// those outputs and the branch stall are tied to 0.
//
// Handshake: there is no valid/ready traffic here. Every output is a combinational
// function of the registered shadow stages plus the current decode inputs, and is
// meant to be sampled by the surrounding pipeline at the next rising clk edge.
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [4:0]  write_reg_d,
  input  logic        reg_write_d,
  input  logic        mem_to_reg_d,
  input  logic        branch_d,
  input  logic        pc_src_d,
  output logic [1:0]  forward_ae,
  output logic [1:0]  forward_be,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_e,
  output logic        flush_d,
  output logic        forward_ad,
  output logic        forward_bd,
  output logic [15:0] stall_cnt
);

  // One pipeline slot as seen by the hazard logic.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] write_reg;
    logic       reg_write;
    logic       mem_to_reg;
  } stage_t;

  // An all-zero slot is a bubble: it writes nothing, so it can never match.
  localparam stage_t BUBBLE = '0;

  // Operand mux select encodings for the execute-stage ALU inputs.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  stage_t stage_e;
  stage_t stage_m;
  stage_t stage_w;
  stage_t decode_slot;

  logic   lw_stall;
  logic   branch_stall;
  logic   stall;

  // A producing slot is only relevant when it really writes a non-zero register.
  function automatic logic writes_reg(input stage_t s, input logic [4:0] src);
    return s.reg_write && (s.write_reg != 5'd0) && (s.write_reg == src);
  endfunction

  // Destination of a slot matches either decode source; register 0 never matches.
  function automatic logic dest_hits_decode(input stage_t s, input logic [4:0] a,
                                            input logic [4:0] b);
    return (s.write_reg != 5'd0) && ((s.write_reg == a) || (s.write_reg == b));
  endfunction

  // Execute operand select: memory stage wins over writeback when both match.
  function automatic logic [1:0] operand_select(input logic [4:0] src, input stage_t m,
                                                input stage_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (writes_reg(m, src)) begin
      sel = FWD_MEM;
    end else if (writes_reg(w, src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Pack the decode-stage fields into the slot that will enter E.
  always_comb begin
    decode_slot            = BUBBLE;
    decode_slot.rs         = rs_d;
    decode_slot.rt         = rt_d;
    decode_slot.write_reg  = write_reg_d;
    decode_slot.reg_write  = reg_write_d;
    decode_slot.mem_to_reg = mem_to_reg_d;
  end

  // Advance the shadow pipeline; a stall inserts a bubble into E.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_e <= BUBBLE;
      stage_m <= BUBBLE;
      stage_w <= BUBBLE;
    end else begin
      stage_e <= stall ? BUBBLE : decode_slot;
      stage_m <= stage_e;
      stage_w <= stage_m;
    end
  end

  // Execute-stage operand forwarding selects.
  always_comb begin
    forward_ae = operand_select(stage_e.rs, stage_m, stage_w);
    forward_be = operand_select(stage_e.rt, stage_m, stage_w);
  end

  // Load-use: a load in E whose result the instruction in decode needs.
  always_comb begin
    lw_stall = stage_e.mem_to_reg && dest_hits_decode(stage_e, rs_d, rt_d);
  end

`ifdef BRANCH_FWD_EN
  // Branch comparator forwarding from M, plus stalls for results not yet available.
  always_comb begin
    forward_ad   = writes_reg(stage_m, rs_d);
    forward_bd   = writes_reg(stage_m, rt_d);
    branch_stall = branch_d &&
                   ((stage_e.reg_write && dest_hits_decode(stage_e, rs_d, rt_d)) ||
                    (stage_m.mem_to_reg && dest_hits_decode(stage_m, rs_d, rt_d)));
  end
`else
  // Branch comparator forwarding is absent: no decode forwarding, no branch stall.
  always_comb begin
    forward_ad   = 1'b0;
    forward_bd   = 1'b0;
    branch_stall = 1'b0;
  end

  // Fields only the branch logic would consume.
  logic unused_branch_fields;
  assign unused_branch_fields = ^{branch_d, stage_e.reg_write, stage_m.mem_to_reg};
`endif

  // Pipeline control: freeze F/D and bubble E on any stall; squash D on a taken branch.
  always_comb begin
    stall   = lw_stall || branch_stall;
    stall_f = stall;
    stall_d = stall;
    flush_e = stall;
    flush_d = pc_src_d && !stall;
  end

  // Count stalled cycles, holding at the maximum instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Source fields of later stages are carried for observability only.
  logic unused_stage_fields;
  assign unused_stage_fields = ^{stage_m.rs, stage_m.rt, stage_w.rs, stage_w.rt,
                                 stage_w.mem_to_reg};

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized and directed checks of hazard_unit against an
// instruction-history reference model. Honors BRANCH_FWD_EN the same way the DUT does.
module tb_hazard_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
    logic       rw;
    logic       mtr;
  } ins_t;

  localparam ins_t NOP = '0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [4:0]  rs_d, rt_d, write_reg_d;
  logic        reg_write_d, mem_to_reg_d, branch_d, pc_src_d;
  logic [1:0]  forward_ae, forward_be;
  logic        stall_f, stall_d, flush_e, flush_d, forward_ad, forward_bd;
  logic [15:0] stall_cnt;

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .write_reg_d(write_reg_d),
    .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d),
    .branch_d(branch_d), .pc_src_d(pc_src_d),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .flush_d(flush_d),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .stall_cnt(stall_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;
  // Issued instruction history: [0] oldest (in W), [1] in M, [2] in E.
  ins_t        hist[$];
  ins_t        cur;
  logic        exp_stall;
  int unsigned exp_cnt;
  int unsigned cnt_before;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int rs, input int rt, input int wr, input bit rw,
                              input bit mtr);
    ins_t i;
    i.rs = 5'(rs); i.rt = 5'(rt); i.wr = 5'(wr); i.rw = rw; i.mtr = mtr;
    return i;
  endfunction

  function automatic bit dest_in(input ins_t x, input logic [4:0] a, input logic [4:0] b);
    return (x.wr != 0) && (x.wr == a || x.wr == b);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (hist[1].rw && hist[1].wr != 0 && hist[1].wr == src) return 2'b10;
    if (hist[0].rw && hist[0].wr != 0 && hist[0].wr == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    hist = {NOP, NOP, NOP};
    exp_cnt = 0;
    exp_stall = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Present decode inputs, then compare every output with the model.
  task automatic drive(input ins_t i, input logic br, input logic pcs);
    bit lw, bs, fad, fbd;
    cur = i;
    rs_d = i.rs; rt_d = i.rt; write_reg_d = i.wr;
    reg_write_d = i.rw; mem_to_reg_d = i.mtr;
    branch_d = br; pc_src_d = pcs;
    #1;
    lw = hist[2].mtr && dest_in(hist[2], i.rs, i.rt);
`ifdef BRANCH_FWD_EN
    bs  = br && ((hist[2].rw && dest_in(hist[2], i.rs, i.rt)) ||
                 (hist[1].mtr && dest_in(hist[1], i.rs, i.rt)));
    fad = (i.rs != 0) && (i.rs == hist[1].wr) && hist[1].rw;
    fbd = (i.rt != 0) && (i.rt == hist[1].wr) && hist[1].rw;
`else
    bs = 0; fad = 0; fbd = 0;
`endif
    exp_stall = lw || bs;
    check("forward_ae", 32'(forward_ae), 32'(m_fwd(hist[2].rs)));
    check("forward_be", 32'(forward_be), 32'(m_fwd(hist[2].rt)));
    check("stall_f", 32'(stall_f), 32'(exp_stall));
    check("stall_d", 32'(stall_d), 32'(exp_stall));
    check("flush_e", 32'(flush_e), 32'(exp_stall));
    check("flush_d", 32'(flush_d), 32'(pcs && !exp_stall));
    check("forward_ad", 32'(forward_ad), 32'(fad));
    check("forward_bd", 32'(forward_bd), 32'(fbd));
    check("stall_cnt", 32'(stall_cnt), exp_cnt);
  endtask

  // Take one clock edge and advance the model the same way.
  task automatic tick();
    @(posedge clk);
    hist.push_back(exp_stall ? NOP : cur);
    void'(hist.pop_front());
    if (exp_stall && exp_cnt < 32'hFFFF) exp_cnt++;
    @(negedge clk);
  endtask

  task automatic random_cycles(input int n);
    ins_t i;
    for (int k = 0; k < n; k++) begin
      if (!(exp_stall && $urandom_range(0, 1) == 1)) begin
        i.rs  = 5'($urandom_range(0, 7));
        i.rt  = 5'($urandom_range(0, 7));
        i.wr  = 5'($urandom_range(0, 7));
        i.rw  = 1'($urandom_range(0, 1));
        i.mtr = i.rw && ($urandom_range(0, 2) == 0);
      end else begin
        i = cur;
      end
      drive(i, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    cur = NOP;
    rs_d = 0; rt_d = 0; write_reg_d = 0; reg_write_d = 0; mem_to_reg_d = 0;
    branch_d = 0; pc_src_d = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state: only pc_src_d may show through (as flush_d).
    drive(mk(3, 3, 3, 1, 1), 1'b1, 1'b1);
    check("rst_forward_ae", 32'(forward_ae), 32'd0);
    check("rst_stall_d", 32'(stall_d), 32'd0);
    check("rst_flush_d", 32'(flush_d), 32'd1);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // Back-to-back ALU hazard, then one instruction in between.
    drive(mk(1, 2, 3, 1, 0), 0, 0); tick();
    drive(mk(3, 4, 6, 1, 0), 0, 0); tick();
    drive(NOP, 0, 0); check("b2b_forward_ae", 32'(forward_ae), 32'd2); tick();
    drive(mk(1, 2, 3, 1, 0), 0, 0); tick();
    drive(mk(9, 9, 9, 1, 0), 0, 0); tick();
    drive(mk(3, 0, 7, 1, 0), 0, 0); tick();
    drive(NOP, 0, 0); check("gap_forward_ae", 32'(forward_ae), 32'd1); tick();

    // Double hazard on $4: memory stage wins.
    drive(mk(0, 0, 4, 1, 0), 0, 0); tick();
    drive(mk(0, 0, 4, 1, 0), 0, 0); tick();
    drive(mk(0, 4, 8, 1, 0), 0, 0); tick();
    drive(NOP, 0, 0); check("double_forward_be", 32'(forward_be), 32'd2); tick();

    // Load-use on $5: exactly one stall, then writeback forwarding.
    drive(mk(0, 0, 5, 1, 1), 0, 0); tick();
    cnt_before = exp_cnt;
    drive(mk(5, 0, 10, 1, 0), 0, 1);
    check("lu_stall_f", 32'(stall_f), 32'd1);
    check("lu_flush_e", 32'(flush_e), 32'd1);
    check("lu_flush_d_masked", 32'(flush_d), 32'd0);
    tick();
    drive(mk(5, 0, 10, 1, 0), 0, 0);
    check("lu_stall_released", 32'(stall_d), 32'd0);
    check("lu_stall_cnt", 32'(stall_cnt), cnt_before + 1);
    tick();
    drive(NOP, 0, 0); check("lu_forward_ae", 32'(forward_ae), 32'd1); tick();

    // Register 0 never forwards or stalls.
    drive(mk(0, 0, 0, 1, 0), 0, 0); tick();
    drive(mk(0, 0, 0, 1, 0), 0, 0); tick();
    drive(mk(0, 0, 0, 1, 1), 0, 0); tick();
    drive(mk(0, 0, 11, 1, 0), 0, 0);
    check("r0_stall_d", 32'(stall_d), 32'd0);
    check("r0_forward_ae", 32'(forward_ae), 32'd0);
    tick();

    // Branch on $7 right after an ALU write of $7.
    drive(mk(1, 2, 7, 1, 0), 0, 0); tick();
    drive(mk(7, 0, 0, 0, 0), 1, 0);
`ifdef BRANCH_FWD_EN
    check("br_stall_d", 32'(stall_d), 32'd1);
    tick();
    drive(mk(7, 0, 0, 0, 0), 1, 0);
    check("br_stall_done", 32'(stall_d), 32'd0);
    check("br_forward_ad", 32'(forward_ad), 32'd1);
`else
    check("br_stall_d", 32'(stall_d), 32'd0);
    check("br_forward_ad", 32'(forward_ad), 32'd0);
`endif
    tick();

    random_cycles(400);

    // Saturation: preload the counter near its maximum, then keep stalling.
    force dut.stall_cnt = 16'hFFFD;
    #1;
    release dut.stall_cnt;
    exp_cnt = 32'hFFFD;
    for (int k = 0; k < 8; k++) begin
      drive(mk(5, 5, 5, 1, 1), 0, 0);
      tick();
    end
    check("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);

    // Asynchronous reset in the middle of a load-use stall.
    drive(mk(5, 5, 5, 1, 1), 0, 0);
    for (int k = 0; k < 3 && !exp_stall; k++) begin
      tick();
      drive(mk(5, 5, 5, 1, 1), 0, 0);
    end
    check("pre_rst_stall_d", 32'(stall_d), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_stall_d", 32'(stall_d), 32'd0);
    check("arst_flush_e", 32'(flush_e), 32'd0);
    check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    rst = 1'b0;
    #1;
    drive(mk(5, 5, 5, 1, 1), 0, 0);
    check("post_rst_no_stall", 32'(stall_d), 32'd0);
    tick();

    random_cycles(100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
